// File: rtl/bpu_tournament.sv
// bpu_tournament: tournament branch predictor (local PHT + gshare global PHT
// + chooser) with a direct-mapped BTB for the 5-stage MIPS pipeline.
// Fetch side performs a registered lookup; commit side trains all tables.
// Optional build macro BPU_STATS_EN adds saturating statistics counters.
module bpu_tournament #(
  parameter int PHT_IDX_W = 6,
  parameter int GHR_W     = 6,
  parameter int BTB_IDX_W = 4,
  parameter int CNT_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_en,
  input  logic [31:0]       pcF,
  output logic              pred_taken,
  output logic              pred_hit,
  output logic [31:0]       pred_target,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic [GHR_W-1:0]  upd_ghr,
  input  logic              upd_mispredict
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispred
`endif
);

  localparam int PHT_ENTRIES = 1 << PHT_IDX_W;
  localparam int BTB_ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W       = 30 - BTB_IDX_W;
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  // Saturating counter helpers shared by all three tables.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] satDec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  logic [CNT_W-1:0]  localPht_q  [PHT_ENTRIES];
  logic [CNT_W-1:0]  globalPht_q [PHT_ENTRIES];
  logic [CNT_W-1:0]  chooser_q   [PHT_ENTRIES];
  logic [GHR_W-1:0]  ghr_q;
  logic [BTB_ENTRIES-1:0] btbValid_q;
  logic [TAG_W-1:0]  btbTag_q    [BTB_ENTRIES];
  logic [31:0]       btbTarget_q [BTB_ENTRIES];

  logic              predTaken_q;
  logic              predHit_q;
  logic [31:0]       predTarget_q;
  logic [GHR_W-1:0]  predGhr_q;

  // Fetch-side indexing reads the tables before any same-cycle training.
  logic [PHT_IDX_W-1:0] lookupLi;
  logic [PHT_IDX_W-1:0] lookupGi;
  logic [BTB_IDX_W-1:0] lookupBtbIdx;
  logic                 lookupHit;
  logic                 lookupChosen;
  logic                 predTaken_d;
  logic [31:0]          predTarget_d;

  assign lookupLi     = pcF[PHT_IDX_W+1:2];
  assign lookupGi     = lookupLi ^ PHT_IDX_W'(ghr_q);
  assign lookupBtbIdx = pcF[BTB_IDX_W+1:2];
  assign lookupHit    = btbValid_q[lookupBtbIdx] &&
                        (btbTag_q[lookupBtbIdx] == pcF[31:BTB_IDX_W+2]);
  assign lookupChosen = chooser_q[lookupLi][CNT_W-1] ?
                        globalPht_q[lookupGi][CNT_W-1] :
                        localPht_q[lookupLi][CNT_W-1];
  assign predTaken_d  = lookupChosen && lookupHit;
  assign predTarget_d = lookupHit ? btbTarget_q[lookupBtbIdx] : 32'h0;

  // Commit-side indices and next counter values for the resolved branch.
  logic [PHT_IDX_W-1:0] updLi;
  logic [PHT_IDX_W-1:0] updGi;
  logic [BTB_IDX_W-1:0] updBtbIdx;
  logic [CNT_W-1:0]     localNew_d;
  logic [CNT_W-1:0]     globalNew_d;
  logic [CNT_W-1:0]     chooserNew_d;
  logic [GHR_W-1:0]     ghr_d;
  logic                 localCorrect;
  logic                 globalCorrect;

  assign updLi     = upd_pc[PHT_IDX_W+1:2];
  assign updGi     = updLi ^ PHT_IDX_W'(upd_ghr);
  assign updBtbIdx = upd_pc[BTB_IDX_W+1:2];
  assign ghr_d     = GHR_W'({ghr_q, upd_taken});

  // Train both PHTs toward the outcome; the chooser moves toward whichever
  // component alone was right, judged on the pre-update counter MSBs.
  always_comb begin
    localNew_d    = localPht_q[updLi];
    globalNew_d   = globalPht_q[updGi];
    chooserNew_d  = chooser_q[updLi];
    localCorrect  = (localPht_q[updLi][CNT_W-1] == upd_taken);
    globalCorrect = (globalPht_q[updGi][CNT_W-1] == upd_taken);
    if (upd_taken) begin
      localNew_d  = satInc(localPht_q[updLi]);
      globalNew_d = satInc(globalPht_q[updGi]);
    end else begin
      localNew_d  = satDec(localPht_q[updLi]);
      globalNew_d = satDec(globalPht_q[updGi]);
    end
    if (globalCorrect && !localCorrect) begin
      chooserNew_d = satInc(chooser_q[updLi]);
    end else if (localCorrect && !globalCorrect) begin
      chooserNew_d = satDec(chooser_q[updLi]);
    end
  end

  // Prediction registers capture a new lookup only when fetch advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      predTaken_q  <= 1'b0;
      predHit_q    <= 1'b0;
      predTarget_q <= 32'h0;
      predGhr_q    <= '0;
    end else if (lookup_en) begin
      predTaken_q  <= predTaken_d;
      predHit_q    <= lookupHit;
      predTarget_q <= predTarget_d;
      predGhr_q    <= ghr_q;
    end
  end

  // Direction tables and committed history, trained at branch resolution.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        localPht_q[i]  <= CNT_WEAK_NT;
        globalPht_q[i] <= CNT_WEAK_NT;
        chooser_q[i]   <= CNT_WEAK_NT;
      end
      ghr_q <= '0;
    end else if (upd_en) begin
      localPht_q[updLi]  <= localNew_d;
      globalPht_q[updGi] <= globalNew_d;
      chooser_q[updLi]   <= chooserNew_d;
      ghr_q              <= ghr_d;
    end
  end

  // BTB valid bits; only taken branches allocate or overwrite an entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btbValid_q <= '0;
    end else if (upd_en && upd_taken) begin
      btbValid_q[updBtbIdx] <= 1'b1;
    end
  end

  // BTB payload needs no reset because the valid bit qualifies every read.
  always_ff @(posedge clk) begin
    if (upd_en && upd_taken) begin
      btbTag_q[updBtbIdx]    <= upd_pc[31:BTB_IDX_W+2];
      btbTarget_q[updBtbIdx] <= upd_target;
    end
  end

  assign pred_taken  = predTaken_q;
  assign pred_hit    = predHit_q;
  assign pred_target = predTarget_q;
  assign pred_ghr    = predGhr_q;

  // Byte-offset PC bits never select an instruction and are ignored.
  logic unusedPcBits;
  assign unusedPcBits = ^{pcF[1:0], upd_pc[1:0]};

`ifdef BPU_STATS_EN
  logic [31:0] statLookups_q;
  logic [31:0] statBranches_q;
  logic [31:0] statMispred_q;

  // Event counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      statLookups_q  <= 32'h0;
      statBranches_q <= 32'h0;
      statMispred_q  <= 32'h0;
    end else begin
      if (lookup_en && (statLookups_q != 32'hFFFFFFFF)) begin
        statLookups_q <= statLookups_q + 32'd1;
      end
      if (upd_en && (statBranches_q != 32'hFFFFFFFF)) begin
        statBranches_q <= statBranches_q + 32'd1;
      end
      if (upd_en && upd_mispredict && (statMispred_q != 32'hFFFFFFFF)) begin
        statMispred_q <= statMispred_q + 32'd1;
      end
    end
  end

  assign stat_lookups  = statLookups_q;
  assign stat_branches = statBranches_q;
  assign stat_mispred  = statMispred_q;
`else
  logic unusedMispredict;
  assign unusedMispredict = upd_mispredict;
`endif

endmodule
